// File: rtl/peripheral_dbg_soc_osd_timestamp_capture_pkg.sv
// Shared types and sizing helpers for the debug timestamp capture block.
package peripheral_dbg_soc_osd_timestamp_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CHAN_W = chan_w(DEF_CHANNELS);

    // Record layout for the default build; the top re-declares it with its own widths.
    typedef struct packed {
        logic                  lost;
        logic [DEF_CHAN_W-1:0] chan_id;
        logic [DEF_WIDTH-1:0]  ts;
    } ts_rec_t;

endpackage

// File: rtl/peripheral_dbg_soc_osd_timestamp_capture_if.sv
// Capture record stream (valid/ready) from the timestamp block toward the trace packetiser.
interface peripheral_dbg_soc_osd_timestamp_capture_if #(
    parameter int WIDTH  = 16,
    parameter int CHAN_W = 2
);
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH+CHAN_W:0]   out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/peripheral_dbg_soc_osd_timestamp_rr_arbiter.sv
// Round-robin grant over full capture slots; a grant offered but not accepted is held.
module peripheral_dbg_soc_osd_timestamp_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                ready,
    output logic                valid,
    output logic [CHAN_W-1:0]   sel
);

    logic [CHAN_W-1:0] ptr;
    logic [CHAN_W-1:0] hold_sel;
    logic              hold_vld;
    logic [CHAN_W-1:0] pick;
    logic              found;
    int                idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(ptr) + i) % CHANNELS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = CHAN_W'(idx);
            end
        end
    end

    assign valid = |req;
    // Slots only empty through a transfer, so a held grant always still points at a full slot.
    assign sel   = hold_vld ? hold_sel : pick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            hold_vld <= 1'b0;
        end else if (valid && ready) begin
            ptr      <= (sel == CHAN_W'(CHANNELS - 1)) ? '0 : sel + CHAN_W'(1);
            hold_vld <= 1'b0;
        end else if (valid) begin
            hold_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (valid && !ready) hold_sel <= sel;
    end

endmodule

// File: rtl/peripheral_dbg_soc_osd_timestamp_capture.sv
// Prescaled free-running timestamp with per-channel event capture and a round-robin record stream.
// Optional build macro PERIPHERAL_DBG_SOC_OSD_TIMESTAMP_LOAD_EN adds a synchronous counter load.
module peripheral_dbg_soc_osd_timestamp_capture
    import peripheral_dbg_soc_osd_timestamp_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int PRESCALE_WIDTH = 8,
    localparam int CHAN_W        = chan_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale_div,
`ifdef PERIPHERAL_DBG_SOC_OSD_TIMESTAMP_LOAD_EN
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
`endif
    input  logic [CHANNELS-1:0]       event_in,
    output logic [WIDTH-1:0]          timestamp,
    output logic                      wrap,
    peripheral_dbg_soc_osd_timestamp_capture_if.master out_if
);

    typedef struct packed {
        logic              lost;
        logic [CHAN_W-1:0] chan_id;
        logic [WIDTH-1:0]  ts;
    } rec_t;

    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic                      tick;
    logic [CHANNELS-1:0]       full;
    logic [CHANNELS-1:0]       pend;
    logic [CHANNELS-1:0]       slot_lost;
    logic [WIDTH-1:0]          slot_ts [CHANNELS];
    logic [CHANNELS-1:0]       drain;
    logic [CHAN_W-1:0]         sel;
    logic                      arb_valid;
    logic                      xfer;
    rec_t                      rec;

    assign tick = enable && (pcnt == prescale_div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            timestamp <= '0;
            pcnt      <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
`ifdef PERIPHERAL_DBG_SOC_OSD_TIMESTAMP_LOAD_EN
            if (load) begin
                timestamp <= load_value;
                pcnt      <= '0;
            end else
`endif
            if (tick) begin
                timestamp <= timestamp + WIDTH'(1);
                pcnt      <= '0;
                wrap      <= &timestamp;
            end else if (enable) begin
                pcnt <= pcnt + PRESCALE_WIDTH'(1);
            end
        end
    end

    peripheral_dbg_soc_osd_timestamp_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (full),
        .ready (out_if.out_ready),
        .valid (arb_valid),
        .sel   (sel)
    );

    assign xfer = arb_valid && out_if.out_ready;

    always_comb begin
        drain = '0;
        for (int c = 0; c < CHANNELS; c++) drain[c] = xfer && (sel == CHAN_W'(c));
    end

    // A slot draining this cycle can accept a new capture, so back-to-back events are not lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= '0;
            pend <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (event_in[c] && (!full[c] || drain[c])) begin
                    full[c]      <= 1'b1;
                    pend[c]      <= 1'b0;
                    slot_lost[c] <= pend[c];
                    slot_ts[c]   <= timestamp;
                end else begin
                    if (event_in[c]) pend[c] <= 1'b1;
                    if (drain[c])    full[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rec.lost    = slot_lost[sel];
        rec.chan_id = sel;
        rec.ts      = slot_ts[sel];
    end

    assign out_if.out_valid = arb_valid;
    assign out_if.out_data  = arb_valid ? rec : '0;

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_timestamp_capture.sv
// Bench: directed scenarios plus randomized traffic checked each cycle against a behavioural model.
module tb_peripheral_dbg_soc_osd_timestamp_capture;
    import peripheral_dbg_soc_osd_timestamp_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] div;
    logic [3:0] ev;
    logic       ready;
    logic [15:0] timestamp;
    logic        wrap;
    logic [3:0]  timestamp4;
    logic        wrap4;

    int nvec = 0;
    int nbad = 0;
    bit chk_en = 0;

    peripheral_dbg_soc_osd_timestamp_capture_if #(.WIDTH(16), .CHAN_W(2)) out_if ();
    peripheral_dbg_soc_osd_timestamp_capture_if #(.WIDTH(4),  .CHAN_W(1)) out4_if ();

    assign out_if.out_ready  = ready;
    assign out4_if.out_ready = 1'b1;

    peripheral_dbg_soc_osd_timestamp_capture #(.WIDTH(16), .CHANNELS(4), .PRESCALE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .prescale_div(div), .event_in(ev),
        .timestamp(timestamp), .wrap(wrap), .out_if(out_if.master));

    peripheral_dbg_soc_osd_timestamp_capture #(.WIDTH(4), .CHANNELS(1), .PRESCALE_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .prescale_div(div), .event_in(1'b0),
        .timestamp(timestamp4), .wrap(wrap4), .out_if(out4_if.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_ts, m_pcnt, m_ptr, m_last_sel;
    bit m_wrap, m_stall;
    bit m_full [4];
    bit m_pend [4];
    bit m_lost [4];
    int m_tss  [4];
    int m4_ts, m4_pcnt;
    bit m4_wrap;

    function automatic bit m_valid();
        return m_full[0] | m_full[1] | m_full[2] | m_full[3];
    endfunction

    function automatic int m_sel();
        if (m_stall) return m_last_sel;
        for (int i = 0; i < 4; i++)
            if (m_full[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return 0;
    endfunction

    task automatic model_step();
        bit v, x, dr;
        int s;
        if (!rst) begin
            m_ts = 0; m_pcnt = 0; m_wrap = 0; m_ptr = 0; m_stall = 0; m_last_sel = 0;
            for (int c = 0; c < 4; c++) begin m_full[c] = 0; m_pend[c] = 0; end
            m4_ts = 0; m4_pcnt = 0; m4_wrap = 0;
            return;
        end
        v = m_valid();
        s = m_sel();
        x = v && ready;
        for (int c = 0; c < 4; c++) begin
            dr = x && (s == c);
            if (ev[c] && (!m_full[c] || dr)) begin
                m_full[c] = 1; m_tss[c] = m_ts; m_lost[c] = m_pend[c]; m_pend[c] = 0;
            end else begin
                if (ev[c]) m_pend[c] = 1;
                if (dr) m_full[c] = 0;
            end
        end
        if (x) m_ptr = (s + 1) % 4;
        m_stall = v && !ready;
        m_last_sel = s;
        m_wrap = 0;
        m4_wrap = 0;
        if (enable) begin
            if (m_pcnt == int'(div)) begin
                m_wrap = (m_ts == 65535);
                m_ts = (m_ts + 1) % 65536;
                m_pcnt = 0;
            end else m_pcnt = (m_pcnt + 1) % 256;
            if (m4_pcnt == int'(div)) begin
                m4_wrap = (m4_ts == 15);
                m4_ts = (m4_ts + 1) % 16;
                m4_pcnt = 0;
            end else m4_pcnt = (m4_pcnt + 1) % 256;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            ts_rec_t e;
            int s;
            e = '0;
            s = m_sel();
            if (m_valid()) begin
                e.lost    = m_lost[s];
                e.chan_id = 2'(s);
                e.ts      = 16'(m_tss[s]);
            end
            chk("model_timestamp", 32'(timestamp), 32'(m_ts));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("model_out_valid", 32'(out_if.out_valid), 32'(m_valid()));
            chk("model_out_data", 32'(out_if.out_data), 32'(e));
            chk("model_timestamp4", 32'(timestamp4), 32'(m4_ts));
            chk("model_wrap4", 32'(wrap4), 32'(m4_wrap));
            chk("model_out_valid4", 32'(out4_if.out_valid), 32'(0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; div = 8'd0; ev = 4'd0; ready = 1'b1;
        cyc(2);
        chk_en = 1;
        chk("rst_timestamp", 32'(timestamp), 32'd0);
        chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(out_if.out_data), 32'd0);

        // Prescale 0: one tick per enabled cycle, then reset clears it
        rst = 1'b1; enable = 1'b1; cyc(5);
        chk("count5", 32'(timestamp), 32'd5);
        rst = 1'b0; cyc(1);
        chk("count_rst", 32'(timestamp), 32'd0);
        chk("count_rst_valid", 32'(out_if.out_valid), 32'd0);

        // Prescale 3 then hold
        rst = 1'b1; div = 8'd3; cyc(12);
        chk("prescale3", 32'(timestamp), 32'd3);
        enable = 1'b0; cyc(4);
        chk("hold", 32'(timestamp), 32'd3);

        // 4-bit wrap
        rst = 1'b0; cyc(1);
        rst = 1'b1; div = 8'd0; enable = 1'b1; cyc(15);
        chk("w4_ts15", 32'(timestamp4), 32'd15);
        chk("w4_nowrap", 32'(wrap4), 32'd0);
        cyc(1);
        chk("w4_ts0", 32'(timestamp4), 32'd0);
        chk("w4_wrap", 32'(wrap4), 32'd1);
        cyc(1);
        chk("w4_wrap_clear", 32'(wrap4), 32'd0);

        // Single capture on channel 2 at ts=7
        rst = 1'b0; cyc(1);
        rst = 1'b1; enable = 1'b1; cyc(7);
        enable = 1'b0; ev = 4'b0100; ready = 1'b1; cyc(1);
        ev = 4'b0000;
        chk("cap2_valid", 32'(out_if.out_valid), 32'd1);
        chk("cap2_data", 32'(out_if.out_data), 32'h20007);
        cyc(1);
        chk("cap2_drained", 32'(out_if.out_valid), 32'd0);

        // Lost event while slot occupied
        rst = 1'b0; cyc(1);
        rst = 1'b1; enable = 1'b1; cyc(3);
        enable = 1'b0; ready = 1'b0; ev = 4'b0010; cyc(1);
        ev = 4'b0000; enable = 1'b1; cyc(2);
        enable = 1'b0; ev = 4'b0010; cyc(1);
        ev = 4'b0000;
        chk("lost_first_rec", 32'(out_if.out_data), 32'h10003);
        ready = 1'b1; cyc(1);
        chk("lost_drained", 32'(out_if.out_valid), 32'd0);
        enable = 1'b1; cyc(4);
        enable = 1'b0; ev = 4'b0010; cyc(1);
        ev = 4'b0000;
        chk("lost_flag_rec", 32'(out_if.out_data), 32'h50009);
        cyc(1);
        chk("lost_flag_drained", 32'(out_if.out_valid), 32'd0);

        // All four channels together, then round-robin wrap to ch0
        rst = 1'b0; cyc(1);
        rst = 1'b1; enable = 1'b1; cyc(10);
        enable = 1'b0; ev = 4'b1111; cyc(1);
        ev = 4'b0000;
        chk("rr_ch0", 32'(out_if.out_data), 32'h0000A);
        cyc(1);
        chk("rr_ch1", 32'(out_if.out_data), 32'h1000A);
        cyc(1);
        chk("rr_ch2", 32'(out_if.out_data), 32'h2000A);
        cyc(1);
        chk("rr_ch3", 32'(out_if.out_data), 32'h3000A);
        ev = 4'b0001; cyc(1);
        ev = 4'b0000;
        chk("rr_wrap_ch0", 32'(out_if.out_data), 32'h0000A);
        cyc(1);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 3));
            ev     = 4'($urandom & $urandom);
            ready  = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
